alu_seq_ctrl: RTL
=================

ALU_SEQ_CTRL -- requirements
Module: alu_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request valid; sampled only in IDLE.
REQ-005 opcode  input  4  data-processing opcode (ARM encoding 0000-1111).
REQ-006 cond  input  4  condition field (ARM encoding).
REQ-007 s_bit  input  1  update-flags request.
REQ-008 is_mem  input  1  1 = address-calculation pass; the sequencer supplies the ALU op.
REQ-009 u_bit  input  1  address direction for is_mem: 1 = add, 0 = subtract.
REQ-010 N, Zero, C, V  input  1 each  current PSR flags.
REQ-011 MuxD0  output  1  ALU op-select mux control: 0 = instruction opcode, 1 = alu_sel_cu.
REQ-012 alu_sel_cu  output  5  sequencer-supplied ALU op.
REQ-013 psr_load  output  1  PSR load enable.
REQ-014 rf_load  output  1  register-file write enable.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle completion pulse.
REQ-017 skipped  output  1  qualifies done: condition failed, nothing written.

Function
REQ-018 States SHALL be IDLE, COND, EXEC, WB and DONE.
REQ-019 IDLE, start=1: opcode, cond, s_bit, is_mem and u_bit SHALL be latched; next state COND.
REQ-020 start SHALL be ignored while busy=1; latched fields SHALL NOT change until the next IDLE acceptance.
REQ-021 COND SHALL evaluate the latched cond against N/Zero/C/V sampled in that cycle, using the ARM table: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE and AL=1110; 1111 SHALL evaluate false.
REQ-022 COND with pass: next state EXEC. COND with fail: next state DONE, and skipped is set.
REQ-023 EXEC with is_mem=0: MuxD0=0. EXEC with is_mem=1: MuxD0=1 and alu_sel_cu=5'b00100 (ADD) when u_bit=1, else 5'b00010 (SUB).
REQ-024 psr_load SHALL be 1 for exactly the EXEC cycle when s_bit=1 and is_mem=0; otherwise 0.
REQ-025 Opcodes 1000-1011 (TST/TEQ/CMP/CMN) SHALL force psr_load in EXEC regardless of s_bit, unless is_mem=1.
REQ-026 EXEC SHALL always go to WB.
REQ-027 rf_load SHALL be 1 for the WB cycle unless the opcode is 1000-1011 or is_mem=1.
REQ-028 MuxD0 and alu_sel_cu SHALL hold their EXEC values through WB.
REQ-029 WB SHALL always go to DONE.
REQ-030 DONE SHALL raise done for one cycle, with skipped valid for the same cycle, then return to IDLE.
REQ-031 Latency from start acceptance to done SHALL be: 4 cycles on pass (COND, EXEC, WB, DONE); 2 cycles on fail (COND, DONE).
REQ-032 A new start is first accepted in the cycle after DONE.
REQ-033 All outputs SHALL be registered or decoded from state only, with no combinational path from start.
REQ-034 In IDLE and DONE, MuxD0=0 and alu_sel_cu=0.

Reset
REQ-035 Rst_n=0 SHALL force, asynchronously:
- state IDLE;
- MuxD0, alu_sel_cu, psr_load, rf_load, busy, done, skipped all 0;
- latched fields 0.
REQ-036 Reset asserted mid-operation SHALL abort without emitting done; after deassertion, the first start is accepted normally.

Structure
REQ-037 A shared package SHALL hold:
- the state enum;
- the 16 cond code constants;
- ALU op constants ALU_ADD=5'b00100 and ALU_SUB=5'b00010;
- compare-opcode range constants.
REQ-038 Condition evaluation SHALL be a combinational sub-module named cond_eval: inputs cond[3:0], N, Zero, C, V; output pass.

Verification
REQ-039 ADD: opcode=0100, cond=1110, s_bit=1, is_mem=0 -> psr_load=1 in cycle 2, rf_load=1 in cycle 3, done=1 and skipped=0 in cycle 4, MuxD0=0 throughout.
REQ-040 Failed condition: cond=0000 (EQ), Zero=0 -> done=1 and skipped=1 two cycles after acceptance; psr_load=0 and rf_load=0 throughout.
REQ-041 CMP: opcode=1010, s_bit=0, cond=1110 -> psr_load=1 in EXEC, rf_load=0 in WB.
REQ-042 Address pass, is_mem=1:
- u_bit=0 -> MuxD0=1 and alu_sel_cu=00010 in EXEC/WB, psr_load=0, rf_load=0.
- u_bit=1 -> alu_sel_cu=00100.
REQ-043 Signed conditions: each of GE/LT/GT/LE evaluated over all 16 N/Zero/C/V combinations matches the ARM table; cond=1111 always gives skipped=1.
REQ-044 Busy and reset handling:
- start held high while busy -> exactly one transaction;
- Rst_n pulsed low during EXEC -> all outputs 0 immediately, no done;
- next start completes in 4 cycles.

Source files
------------

// File: rtl/alu_seq_ctrl_pkg.sv
// Shared types and constants for the ALU instruction sequencer.
package alu_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COND,
    S_EXEC,
    S_WB,
    S_DONE
  } state_t;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  localparam logic [4:0] ALU_NONE = 5'b00000;
  localparam logic [4:0] ALU_ADD  = 5'b00100;
  localparam logic [4:0] ALU_SUB  = 5'b00010;

  // TST/TEQ/CMP/CMN: flag-only opcodes
  localparam logic [3:0] OPC_CMP_LO = 4'b1000;
  localparam logic [3:0] OPC_CMP_HI = 4'b1011;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] cond;
    logic       s_bit;
    logic       is_mem;
    logic       u_bit;
  } req_t;

  function automatic logic is_cmp_op(input logic [3:0] op);
    return (op >= OPC_CMP_LO) && (op <= OPC_CMP_HI);
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_cond_eval.sv
// ARM condition-code evaluation against the current N/Z/C/V flags.
module cond_eval
  import alu_seq_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       N,
  input  logic       Zero,
  input  logic       C,
  input  logic       V,
  output logic       pass
);

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = Zero;
      COND_NE: pass = ~Zero;
      COND_CS: pass = C;
      COND_CC: pass = ~C;
      COND_MI: pass = N;
      COND_PL: pass = ~N;
      COND_VS: pass = V;
      COND_VC: pass = ~V;
      COND_HI: pass = C & ~Zero;
      COND_LS: pass = ~C | Zero;
      COND_GE: pass = (N == V);
      COND_LT: pass = (N != V);
      COND_GT: pass = ~Zero & (N == V);
      COND_LE: pass = Zero | (N != V);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer for one conditional data-processing or address-calculation pass.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] opcode,
  input  logic [3:0] cond,
  input  logic       s_bit,
  input  logic       is_mem,
  input  logic       u_bit,
  input  logic       N,
  input  logic       Zero,
  input  logic       C,
  input  logic       V,
  output logic       MuxD0,
  output logic [4:0] alu_sel_cu,
  output logic       psr_load,
  output logic       rf_load,
  output logic       busy,
  output logic       done,
  output logic       skipped
);

  state_t state, state_nxt;
  req_t   req_q;
  logic   skip_q, skip_nxt;
  logic   pass;
  logic   cmp_op;

  cond_eval u_cond_eval (
    .cond (req_q.cond),
    .N    (N),
    .Zero (Zero),
    .C    (C),
    .V    (V),
    .pass (pass)
  );

  assign cmp_op = is_cmp_op(req_q.opcode);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      req_q  <= '0;
      skip_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      skip_q <= skip_nxt;
      if (state == S_IDLE && start)
        req_q <= '{opcode: opcode, cond: cond, s_bit: s_bit, is_mem: is_mem, u_bit: u_bit};
    end
  end

  // Outputs depend only on state and latched fields, never on start.
  always_comb begin
    state_nxt  = state;
    skip_nxt   = skip_q;
    MuxD0      = 1'b0;
    alu_sel_cu = ALU_NONE;
    psr_load   = 1'b0;
    rf_load    = 1'b0;
    busy       = (state != S_IDLE);
    done       = 1'b0;
    skipped    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_COND;
          skip_nxt  = 1'b0;
        end
      end
      S_COND: begin
        if (pass) begin
          state_nxt = S_EXEC;
        end else begin
          state_nxt = S_DONE;
          skip_nxt  = 1'b1;
        end
      end
      S_EXEC: begin
        state_nxt  = S_WB;
        MuxD0      = req_q.is_mem;
        alu_sel_cu = req_q.is_mem ? (req_q.u_bit ? ALU_ADD : ALU_SUB) : ALU_NONE;
        psr_load   = ~req_q.is_mem & (req_q.s_bit | cmp_op);
      end
      S_WB: begin
        state_nxt  = S_DONE;
        MuxD0      = req_q.is_mem;
        alu_sel_cu = req_q.is_mem ? (req_q.u_bit ? ALU_ADD : ALU_SUB) : ALU_NONE;
        rf_load    = ~req_q.is_mem & ~cmp_op;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
        done      = 1'b1;
        skipped   = skip_q;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
